washer_sequencer: RTL and testbench

// Upstream command stage for the station washer servo PWM stage. On a docked-vehicle request it

---
 rtl/washer_sequencer.sv | 150 +++++++++++++++
 tb/tb_washer_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/washer_sequencer.sv
// ----------------------------------------------------------------------------
// washer_sequencer
//   Command stage ahead of the washer servo PWM block. When a docked vehicle
//   requests a wash (start), it debounces the request and then runs DIPS
//   servo dip cycles: down / hold, then up / settle. Completion is reported
//   with a four-phase handshake: done stays high until start drops.
//   An abort level forces the servo up and returns to idle after a settle
//   period, without raising done.
//
// Ports
//   CLK          in   system clock, all state changes on posedge
//   RSTn         in   asynchronous active-low reset
//   start        in   request level, held high until done is seen
//   abort        in   abort level, honoured in ARM / DOWN / UP
//   controlServo out  0 = servo up, 1 = servo down (feeds PWM controlServo)
//   busy         out  high in ARM, DOWN, UP, RECOVER
//   done         out  high in DONE only
//   dipCount     out  dips started in the current request
// ----------------------------------------------------------------------------
module washer_sequencer #(
  parameter int TICK_DIV     = 50000,
  parameter int DEBOUNCE     = 5,
  parameter int DOWN_TICKS   = 400,
  parameter int SETTLE_TICKS = 300,
  parameter int DIPS         = 3
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       start,
  input  logic       abort,
  output logic       controlServo,
  output logic       busy,
  output logic       done,
  output logic [3:0] dipCount
);

  typedef enum logic [2:0] {IDLE, ARM, DOWN, UP, DONE, RECOVER} state_e;

  localparam int DW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  state_e      state_q, state_d;
  logic [DW-1:0] div_q;
  logic [15:0] tcnt_q;
  logic [3:0]  dip_q, dip_d;
  logic        servo_q, servo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        tick;
  logic        exp_deb, exp_down, exp_settle;

  // Free-running timebase: tick is a one-clock pulse once per TICK_DIV clocks.
  assign tick = (div_q == DW'(TICK_DIV - 1));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) div_q <= '0;
    else       div_q <= tick ? '0 : div_q + 1'b1;
  end

  // Tick counter restarts on every state entry (including UP -> DOWN).
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)                  tcnt_q <= '0;
    else if (state_d != state_q) tcnt_q <= '0;
    else if (tick)               tcnt_q <= tcnt_q + 16'd1;
  end

  // A period of N ticks expires on the tick seen while tCnt == N-1.
  assign exp_deb    = tick && (tcnt_q == 16'(DEBOUNCE - 1));
  assign exp_down   = tick && (tcnt_q == 16'(DOWN_TICKS - 1));
  assign exp_settle = tick && (tcnt_q == 16'(SETTLE_TICKS - 1));

  // State register plus registered Moore outputs.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= IDLE;
      dip_q   <= '0;
      servo_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dip_q   <= dip_d;
      servo_q <= servo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. Abort is checked before any timer expiry so it wins
  // on a coincident edge.
  always_comb begin
    state_d = state_q;
    dip_d   = dip_q;
    unique case (state_q)
      IDLE: if (start) state_d = ARM;
      ARM: begin
        if (abort)        state_d = RECOVER;
        else if (!start)  state_d = IDLE;
        else if (exp_deb) begin
          state_d = DOWN;
          dip_d   = 4'd1;
        end
      end
      DOWN: begin
        if (abort)         state_d = RECOVER;
        else if (exp_down) state_d = UP;
      end
      UP: begin
        if (abort) state_d = RECOVER;
        else if (exp_settle) begin
          if (dip_q == 4'(DIPS)) state_d = DONE;
          else begin
            state_d = DOWN;
            dip_d   = dip_q + 4'd1;
          end
        end
      end
      DONE: begin
        if (!start) begin
          state_d = IDLE;
          dip_d   = '0;
        end
      end
      RECOVER: begin
        if (exp_settle) begin
          state_d = IDLE;
          dip_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        dip_d   = '0;
      end
    endcase
  end

  // Output decode from the next state, so outputs are registered and aligned
  // with the state they describe.
  always_comb begin
    servo_d = (state_d == DOWN);
    busy_d  = (state_d == ARM) || (state_d == DOWN) ||
              (state_d == UP)  || (state_d == RECOVER);
    done_d  = (state_d == DONE);
  end

  assign controlServo = servo_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign dipCount     = dip_q;

endmodule

// File: tb/tb_washer_sequencer.sv
// ----------------------------------------------------------------------------
// tb_washer_sequencer
//   Directed scenarios plus a randomized soak for washer_sequencer, each
//   clock checked against a phase/ticks-remaining reference model.
// ----------------------------------------------------------------------------
module tb_washer_sequencer;

  localparam int TICK_DIV = 4;
  localparam int DEBOUNCE = 2;
  localparam int DOWN_T   = 3;
  localparam int SETTLE_T = 2;
  localparam int DIPS     = 2;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       controlServo, busy, done;
  logic [3:0] dipCount;

  washer_sequencer #(
    .TICK_DIV(TICK_DIV), .DEBOUNCE(DEBOUNCE), .DOWN_TICKS(DOWN_T),
    .SETTLE_TICKS(SETTLE_T), .DIPS(DIPS)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .start(start), .abort(abort),
    .controlServo(controlServo), .busy(busy), .done(done), .dipCount(dipCount)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: phase name, ticks still to wait, dips started, and the
  // clock count within the current timebase period.
  localparam int P_IDLE = 0, P_ARM = 1, P_DOWN = 2, P_UP = 3, P_DONE = 4, P_REC = 5;
  int m_ph, m_left, m_dips, m_div;

  task automatic model_reset();
    m_ph = P_IDLE; m_left = 0; m_dips = 0; m_div = 0;
  endtask

  task automatic go_recover();
    m_ph = P_REC; m_left = SETTLE_T;
  endtask

  task automatic model_step();
    bit tk;
    tk    = (m_div == TICK_DIV - 1);
    m_div = (m_div + 1) % TICK_DIV;
    case (m_ph)
      P_IDLE: if (start) begin m_ph = P_ARM; m_left = DEBOUNCE; end
      P_ARM: begin
        if (abort) go_recover();
        else if (!start) m_ph = P_IDLE;
        else if (tk) begin
          m_left--;
          if (m_left == 0) begin m_ph = P_DOWN; m_left = DOWN_T; m_dips = 1; end
        end
      end
      P_DOWN: begin
        if (abort) go_recover();
        else if (tk) begin
          m_left--;
          if (m_left == 0) begin m_ph = P_UP; m_left = SETTLE_T; end
        end
      end
      P_UP: begin
        if (abort) go_recover();
        else if (tk) begin
          m_left--;
          if (m_left == 0) begin
            if (m_dips == DIPS) m_ph = P_DONE;
            else begin m_ph = P_DOWN; m_left = DOWN_T; m_dips++; end
          end
        end
      end
      P_DONE: if (!start) begin m_ph = P_IDLE; m_dips = 0; end
      P_REC: begin
        if (tk) begin
          m_left--;
          if (m_left == 0) begin m_ph = P_IDLE; m_dips = 0; end
        end
      end
      default: m_ph = P_IDLE;
    endcase
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".servo"}, {3'b0, controlServo}, {3'b0, m_ph == P_DOWN});
    chk({tag, ".busy"},  {3'b0, busy},
        {3'b0, (m_ph == P_ARM) || (m_ph == P_DOWN) || (m_ph == P_UP) || (m_ph == P_REC)});
    chk({tag, ".done"},  {3'b0, done}, {3'b0, m_ph == P_DONE});
    chk({tag, ".dips"},  dipCount, 4'(m_dips));
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge.
  task automatic cyc(input string tag);
    @(posedge CLK);
    if (RSTn) model_step();
    @(negedge CLK);
    chk_all(tag);
  endtask

  task automatic go_idle(input string tag);
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (m_ph == P_IDLE && !busy && !done) break;
      cyc(tag);
    end
    chk({tag, ".idle_reached"}, {3'b0, (!busy && !done)}, 4'd1);
  endtask

  // Full request with start held: measures servo run lengths.
  task automatic full_run(input string tag);
    int   runs[$];
    int   cur;
    logic prev;
    bit   got_done;
    cur = 0; prev = 1'b0; got_done = 0;
    start = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cyc(tag);
      if (done) begin got_done = 1; break; end
      if (controlServo == prev) cur++;
      else begin runs.push_back(cur); cur = 1; prev = controlServo; end
    end
    chk({tag, ".done_seen"}, {3'b0, got_done}, 4'd1);
    chk({tag, ".nruns"}, 4'(runs.size()), 4'd4);
    if (runs.size() == 4) begin
      chk({tag, ".arm_len_ok"}, {3'b0, (runs[0] >= 5 && runs[0] <= 8)}, 4'd1);
      chk({tag, ".down1_len"}, 4'(runs[1]), 4'd12);
      chk({tag, ".up1_len"},   4'(runs[2]), 4'd8);
      chk({tag, ".down2_len"}, 4'(runs[3]), 4'd12);
    end
    chk({tag, ".up2_len"}, 4'(cur), 4'd8);
    chk({tag, ".dips_done"}, dipCount, 4'd2);
    start = 1'b0;
    cyc(tag);
    chk({tag, ".done_drop"}, {3'b0, done}, 4'd0);
    chk({tag, ".dips_clr"}, dipCount, 4'd0);
  endtask

  initial begin
    bit seen;
    int len;
    model_reset();

    // Reset state
    #2;
    chk_all("reset");
    repeat (2) cyc("reset_hold");
    RSTn = 1'b1;
    cyc("post_reset");

    // T1 full run
    full_run("T1");
    go_idle("T1_idle");

    // T2 debounce: 5-clock pulse is shorter than two ticks
    seen = 0;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc("T2");
      if (controlServo) seen = 1;
    end
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc("T2_after");
      if (controlServo) seen = 1;
    end
    chk("T2.servo_never", {3'b0, seen}, 4'd0);
    chk("T2.busy_off", {3'b0, busy}, 4'd0);

    // T3 abort mid first DOWN
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (controlServo) break;
      cyc("T3_wait");
    end
    chk("T3.down_reached", {3'b0, controlServo}, 4'd1);
    repeat (3) cyc("T3_down");
    abort = 1'b1;
    cyc("T3_abort");
    abort = 1'b0; start = 1'b0;
    chk("T3.servo_up", {3'b0, controlServo}, 4'd0);
    chk("T3.busy_rec", {3'b0, busy}, 4'd1);
    seen = 0; len = 1;
    for (int i = 0; i < 40; i++) begin
      cyc("T3_rec");
      if (done) seen = 1;
      if (!busy) break;
      len++;
    end
    chk("T3.rec_len_ok", {3'b0, (len >= 5 && len <= 8)}, 4'd1);
    chk("T3.no_done", {3'b0, seen}, 4'd0);
    chk("T3.dips_clr", dipCount, 4'd0);

    // T4 abort coincident with the DOWN expiry tick
    start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (m_ph == P_DOWN && m_left == 1 && m_div == TICK_DIV - 1) break;
      cyc("T4_wait");
    end
    chk("T4.edge_found", {3'b0, controlServo}, 4'd1);
    abort = 1'b1; start = 1'b0;
    cyc("T4_abort");
    abort = 1'b0;
    len = 1;
    for (int i = 0; i < 40; i++) begin
      cyc("T4_rec");
      if (!busy) break;
      len++;
    end
    chk("T4.rec_len", 4'(len), 4'd8);
    chk("T4.dips_clr", dipCount, 4'd0);

    // T5 async reset mid UP of second dip
    start = 1'b1;
    for (int i = 0; i < 120; i++) begin
      if (m_ph == P_UP && m_dips == 2) break;
      cyc("T5_wait");
    end
    chk("T5.up2_reached", dipCount, 4'd2);
    cyc("T5_up");
    #1 RSTn = 1'b0;
    #1;
    model_reset();
    chk("T5.async_servo", {3'b0, controlServo}, 4'd0);
    chk("T5.async_busy",  {3'b0, busy}, 4'd0);
    chk("T5.async_done",  {3'b0, done}, 4'd0);
    chk("T5.async_dips",  dipCount, 4'd0);
    cyc("T5_in_reset");
    RSTn = 1'b1;
    full_run("T5_rerun");
    go_idle("T5_idle");

    // T6 start dropped during second DOWN
    start = 1'b1;
    for (int i = 0; i < 120; i++) begin
      if (m_ph == P_DOWN && m_dips == 2) break;
      cyc("T6_wait");
    end
    chk("T6.down2_reached", {3'b0, controlServo}, 4'd1);
    start = 1'b0;
    len = 0; seen = 0;
    for (int i = 0; i < 100; i++) begin
      cyc("T6_run");
      if (done) begin len++; seen = 1; end
      if (seen && !done) break;
    end
    chk("T6.done_pulse", 4'(len), 4'd1);
    chk("T6.idle_busy", {3'b0, busy}, 4'd0);
    chk("T6.idle_dips", dipCount, 4'd0);

    // Randomized soak
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) start = ~start;
      abort = ($urandom_range(0, 59) == 0);
      cyc("rand");
    end
    go_idle("rand_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
